mem_dump_serializer: RTL
========================

Name: mem_dump_serializer

Overview:
Read-side companion to the loader path that writes the instruction and data SRAMs. On a start request it reads a run of consecutive 16-bit words from one SRAM pair (two 256x8 macros sharing control). It streams each word out of a single GPIO pin as a UART-style frame, letting the host read back memory contents after a program load or a processor halt. It sits beside the IO interface. When the dump path has memory ownership, the IO interface muxes this block's memory-control outputs onto the selected SRAM pair.

Parameters:
ADDR_W, 8, SRAM word address width (256 words)
DATA_W, 16, word width (LSB macro = [7:0], MSB macro = [15:8])
BAUD_DIV, 4, clk cycles per serial bit; legal range 1..255

Ports:
clk  in  1  single clock for the whole block
reset  in  1  synchronous, active-low reset
start  in  1  request pulse; sampled only in IDLE
start_addr  in  ADDR_W  first word address; captured on accepted start
word_count  in  ADDR_W+1  words to send, 0..256; captured on accepted start
busy  out  1  high while a dump is in progress
done  out  1  one-cycle pulse when a dump completes
mem_cen  out  1  SRAM chip enable, active-low
mem_gwen  out  1  SRAM global write enable, active-low; tied 1 (read-only)
mem_wen  out  8  SRAM per-bit write enable, active-low; tied 8'hFF
mem_addr  out  ADDR_W  SRAM address
mem_q  in  DATA_W  SRAM read data, {MSB.Q, LSB.Q}
ser_out  out  1  serial data; idles high

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE, busy=0, done=0, mem_cen=1, mem_addr=0, ser_out=1. Reset mid-dump aborts immediately and does not pulse done.
- All outputs are registered. mem_gwen=1 and mem_wen=8'hFF at all times.
- FSM states: IDLE, REQ, CAPT, SEND, FIN.
- IDLE: on start=1, capture addr<=start_addr and remaining<=word_count.
  - If word_count==0, go to FIN with no memory access.
  - Otherwise go to REQ; busy=1 from the next cycle.
- REQ (1 cycle): mem_cen=0, mem_addr=addr. The SRAM samples at the end of this cycle.
- CAPT (1 cycle): mem_cen=1. At the end of the cycle, shreg<=mem_q, addr<=addr+1 (mod 256, so 0xFF wraps to 0x00), remaining<=remaining-1.
- SEND: 18-bit frame, each bit held for exactly BAUD_DIV cycles.
  - Order: start bit 0, then shreg[0]..shreg[15] (LSB first), then stop bit 1.
  - A bit counter 0..17 and a baud counter 0..BAUD_DIV-1 control timing.
  - After the last stop-bit cycle: if remaining!=0 go to REQ, else go to FIN.
- FIN (1 cycle): done=1, busy=0, ser_out=1; then go to IDLE.
- Per-word cost is 2 + 18*BAUD_DIV cycles. ser_out=1 during REQ/CAPT between frames, which acts as extra idle time.
- start while not in IDLE (including FIN) is ignored. start_addr and word_count changes after capture have no effect.
- word_count=256 sends all 256 words, with the address wrapping back to start_addr.

Test Plan:
- BAUD_DIV=4, mem[0x10]=0x12A5, start_addr=0x10, count=1 -> one CEN-low cycle at addr 0x10. ser_out frame: 0, then 1,0,1,0,0,1,0,1,0,1,0,0,1,0,0,0, then 1, each bit 4 cycles. busy high 74 cycles, then done pulses once.
- start_addr=0xFF, count=3, mem[FF]=0xAAAA, mem[00]=0x5555, mem[01]=0x0F0F -> CEN-low addresses in order FF, 00, 01. Three frames carry those values; total busy = 3*74 = 222 cycles.
- count=0 -> done pulses on the second cycle after start; mem_cen stays 1; ser_out stays 1; busy never rises.
- Second start pulse issued mid-frame -> ignored: frame content and timing unchanged, exactly one done pulse.
- reset=0 at bit 7 of a frame -> next cycle ser_out=1, mem_cen=1, busy=0, no done. A fresh start afterwards produces a correct full frame.
- count=256, BAUD_DIV=1, start_addr=0x80 -> 256 CEN-low cycles at addresses 80..FF, 00..7F; total busy 256*20 cycles; mem_gwen=1 throughout.

Source files
------------

// File: rtl/mem_dump_serializer.sv
// rtl/mem_dump_serializer.sv - reads consecutive SRAM words and shifts each out as a UART-style frame
module mem_dump_serializer #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int BAUD_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              mem_cen,
  output logic              mem_gwen,
  output logic [7:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic              ser_out
);

  // Frame is start bit, DATA_W data bits, stop bit: bit positions 0..DATA_W+1
  localparam int BIT_W = $clog2(DATA_W + 2);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W + 1);
  localparam logic [7:0]       BAUD_LAST = 8'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    CAPT = 3'd2,
    SEND = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [ADDR_W:0]     remaining, rem_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic [BIT_W-1:0]    bit_cnt, bit_n;
  logic [7:0]          baud_cnt, baud_n;
  logic [IDX_W-1:0]    sidx;
  logic                ser_n;

  // The dump path only ever reads the SRAM pair
  assign mem_gwen = 1'b1;
  assign mem_wen  = 8'hFF;

  // Next-state and datapath updates; the serial level is derived from the next state so ser_out is registered
  always_comb begin
    state_n = state;
    addr_n  = addr;
    rem_n   = remaining;
    shreg_n = shreg;
    bit_n   = bit_cnt;
    baud_n  = baud_cnt;
    sidx    = '0;
    ser_n   = 1'b1;
    case (state)
      IDLE: begin
        if (start) begin
          addr_n  = start_addr;
          rem_n   = word_count;
          state_n = (word_count == '0) ? FIN : REQ;
        end
      end
      REQ: state_n = CAPT;
      CAPT: begin
        shreg_n = mem_q;
        addr_n  = addr + 1'b1;
        rem_n   = remaining - 1'b1;
        bit_n   = '0;
        baud_n  = '0;
        state_n = SEND;
      end
      SEND: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n = '0;
          if (bit_cnt == LAST_BIT) begin
            state_n = (remaining != '0) ? REQ : FIN;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          baud_n = baud_cnt + 8'd1;
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (state_n == SEND) begin
      sidx = IDX_W'(bit_n - 1'b1);
      if (bit_n == '0) begin
        ser_n = 1'b0;
      end else if (bit_n != LAST_BIT) begin
        ser_n = shreg_n[sidx];
      end
    end
  end

  // State, datapath and registered outputs; reset aborts a dump without pulsing done
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_cen   <= 1'b1;
      mem_addr  <= '0;
      ser_out   <= 1'b1;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      remaining <= rem_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_n;
      baud_cnt  <= baud_n;
      busy      <= (state_n == REQ) || (state_n == CAPT) || (state_n == SEND);
      done      <= (state_n == FIN);
      mem_cen   <= (state_n != REQ);
      if (state_n == REQ) begin
        mem_addr <= addr_n;
      end
      ser_out   <= ser_n;
    end
  end

endmodule
